// File: rtl/shift_r_pkg.sv
// ============================================================================
// Module   : shift_r_pkg
// Brief    : Shared types and default sizes for the shift_r_sched block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_r_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned C_DEFAULT_SHIFT_WIDTH = 5;
    localparam int unsigned C_DEFAULT_NREQ        = 4;

endpackage

`default_nettype wire

// File: rtl/shift_r_nbit_arith.sv
// ============================================================================
// Module   : shift_r_nbit_arith
// Brief    : Combinational arithmetic right shift, sign-filled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_r_nbit_arith #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [WIDTH-1:0]       i_a,
    input  logic [SHIFT_WIDTH-1:0] i_shamt,
    output logic [WIDTH-1:0]       o_y
);

    assign o_y = WIDTH'($signed(i_a) >>> i_shamt);

endmodule

`default_nettype wire

// File: rtl/shift_r_sched.sv
// ============================================================================
// Module   : shift_r_sched
// Brief    : Round-robin scheduler sharing one arithmetic right shifter among
//            NREQ requesters, with a one-entry registered result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_r_sched
    import shift_r_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NREQ        = int'(C_DEFAULT_NREQ),
    parameter int SHIFT_WIDTH = int'(C_DEFAULT_SHIFT_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_y,
    output logic [$clog2(NREQ)-1:0]   rsp_id
);

    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q,   ptr_d;
    logic [IDW-1:0]   id_q,    id_d;
    logic [WIDTH-1:0] y_q,     y_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic             accept;
    logic [WIDTH-1:0] a_mux;
    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] shift_y;
    logic             unused_b_hi;

    // Round-robin search; NREQ is a power of two so IDW-bit addition wraps.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[ptr_q + IDW'(k)]) begin
                found = 1'b1;
                win   = ptr_q + IDW'(k);
            end
        end
    end

    assign accept = rst_n && found && ((state_q == EMPTY) || rsp_ready);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (win == IDW'(i));
        end
    end

    assign a_mux       = req_a[win*WIDTH +: WIDTH];
    assign b_mux       = req_b[win*WIDTH +: WIDTH];
    assign unused_b_hi = ^b_mux[WIDTH-1:SHIFT_WIDTH];

    shift_r_nbit_arith #(
        .WIDTH       (WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shift (
        .i_a     (a_mux),
        .i_shamt (b_mux[SHIFT_WIDTH-1:0]),
        .o_y     (shift_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        y_d     = y_q;
        if (accept) begin
            state_d = HOLD;
            ptr_d   = win + IDW'(1);
            id_d    = win;
            y_d     = shift_y;
        end else if ((state_q == HOLD) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            y_q     <= y_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_y     = y_q;
    assign rsp_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_r_sched.sv
// ============================================================================
// Module   : tb_shift_r_sched
// Brief    : Directed self-checking bench for shift_r_sched (NREQ=4, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_r_sched;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int SW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic [1:0]            rsp_id;

    shift_r_sched #(
        .WIDTH       (WIDTH),
        .NREQ        (NREQ),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[1] = '{1, 32'h7FFF_FFFF, 32'h0000_0025, 32'h03FF_FFFF};
        vecs[2] = '{3, 32'hFFFF_FFFF, 32'h0000_001F, 32'hFFFF_FFFF};
        vecs[3] = '{0, 32'h4000_0000, 32'h0000_001F, 32'h0000_0000};
        vecs[4] = '{2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[5] = '{0, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001};
        vecs[6] = '{3, 32'hF0F0_F0F0, 32'h0000_0008, 32'hFFF0_F0F0};
        vecs[7] = '{1, 32'h0000_FF00, 32'hFFFF_FFE4, 32'h0000_0FF0};

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with requests present to confirm req_ready is gated.
        #2;
        req_valid = 4'hF;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_y",     rsp_y,          32'h0);
        check("reset_rsp_id",    32'(rsp_id),    32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single-requester shift vectors; other slots hold random junk.
        for (int v = 0; v < 8; v++) begin
            for (int s = 0; s < NREQ; s++) set_req(s, $urandom, $urandom);
            set_req(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = 4'(1 << vecs[v].id);
            #1;
            check("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].id));
            tick;
            check("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            check("vec_rsp_y",     rsp_y,          vecs[v].y);
            check("vec_rsp_id",    32'(rsp_id),    32'(vecs[v].id));
            req_valid = '0;
        end
        tick;
        check("drain_to_empty", 32'(rsp_valid), 32'h0);

        // Round robin from ptr=0: grants 0,1,2,3,0.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < NREQ; s++) set_req(s, 32'h100 * (s + 1), 32'hABCD_0001);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick;
            check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            check("rr_rsp_id",    32'(rsp_id),    32'(k % 4));
            check("rr_rsp_y",     rsp_y,          32'h80 * ((k % 4) + 1));
        end

        // Backpressure in HOLD holding requester 0's result; ptr is now 1.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_req_ready", 32'(req_ready), 32'h0);
            tick;
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_id",    32'(rsp_id),    32'h0);
            check("bp_rsp_y",     rsp_y,          32'h80);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h2);
        tick;
        check("bp_release_id", 32'(rsp_id), 32'h1);
        check("bp_release_y",  rsp_y,       32'h100);

        // Asynchronous reset mid-HOLD with ptr=2; ptr must return to 0.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_rsp_y",     rsp_y,          32'h0);
        check("async_rsp_id",    32'(rsp_id),    32'h0);
        check("async_req_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h2);
        tick;
        check("post_rst_valid", 32'(rsp_valid), 32'h1);
        check("post_rst_id",    32'(rsp_id),    32'h1);
        check("post_rst_y",     rsp_y,          32'h100);

        // Requester 3 waits under backpressure, then withdraws: never served.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        tick;
        check("wd_hold_id", 32'(rsp_id), 32'h1);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("wd_req_ready", 32'(req_ready), 32'h0);
        tick;
        check("wd_empty", 32'(rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
